seq_restoring_divider: RTL and testbench

- Unsigned multi-cycle restoring divider for the calculator datapath.
- Performs the subtract direction of the arithmetic core: each cycle, one trial subtraction of the divisor from the partial remainder yields one quotient bit.
- Sits beside the adder chain and is driven by the calculator control FSM through a Start/Busy/Done handshake.

---
 rtl/seq_restoring_divider_pkg.sv | 16 +
 rtl/seq_restoring_divider_trial_subtractor.sv | 23 ++
 rtl/seq_restoring_divider.sv | 122 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// Shared calculator constants: divider state encoding, default datapath width
// and the quotient fill value reported for a zero divisor.
package seq_restoring_divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Each quotient bit is forced to this value when the divisor is zero.
    localparam logic DIV0_FILL_BIT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } div_state_t;

endpackage

// File: rtl/seq_restoring_divider_trial_subtractor.sv
// Combinational ripple subtractor (A - B) built from full-subtractor cells.
// Used for the trial subtraction of the divisor from the partial remainder.
module trial_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Diff,
    output logic         BorrowOut
);

    logic [N:0] w_borrow;

    assign w_borrow[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign Diff[i]       = A[i] ^ B[i] ^ w_borrow[i];
        assign w_borrow[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & w_borrow[i]);
    end

    assign BorrowOut = w_borrow[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned multi-cycle restoring divider: one quotient bit per clock, driven by
// a Start/Busy/Done handshake from the calculator control FSM.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_qs;
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH:0]   w_partial;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_next_rem;
    logic [WIDTH-1:0] w_next_qs;
    logic             w_unused_diff_msb;

    // Shift the next dividend bit into the partial remainder before the trial.
    assign w_partial = {r_rem, r_qs[WIDTH-1]};

    trial_subtractor #(
        .N(WIDTH + 1)
    ) u_trial_subtractor (
        .A        (w_partial),
        .B        ({1'b0, r_divisor}),
        .Diff     (w_diff),
        .BorrowOut(w_borrow)
    );

    // A non-borrowing difference is below the divisor, so its MSB is always 0.
    assign w_unused_diff_msb = w_diff[WIDTH];
    assign w_next_rem        = w_borrow ? w_partial[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_next_qs         = {r_qs[WIDTH-2:0], ~w_borrow};

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_qs        <= '0;
            r_divisor   <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    if (Start) begin
                        if (Divisor == '0) begin
                            r_state     <= ST_FIN;
                            r_done      <= 1'b1;
                            r_quotient  <= {WIDTH{DIV0_FILL_BIT}};
                            r_remainder <= Dividend;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_state   <= ST_CALC;
                            r_busy    <= 1'b1;
                            r_rem     <= '0;
                            r_qs      <= Dividend;
                            r_divisor <= Divisor;
                            r_count   <= CW'(WIDTH - 1);
                        end
                    end
                end
                ST_CALC: begin
                    r_rem   <= w_next_rem;
                    r_qs    <= w_next_qs;
                    r_count <= r_count - 1'b1;
                    if (r_count == '0) begin
                        r_state     <= ST_FIN;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_quotient  <= w_next_qs;
                        r_remainder <= w_next_rem;
                        r_dbz       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Quotient  = r_quotient;
    assign Remainder = r_remainder;
    assign DivByZero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: a directed vector table plus
// hand-written sequences for ignored Start, back-to-back Start and mid-op reset.
module tb_seq_restoring_divider;

    localparam int W       = 8;
    localparam int MAX_LAT = 20;

    logic         Clk;
    logic         Rst;
    logic         Start;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         DivByZero;

    int checks = 0;
    int errors = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Busy     (Busy),
        .Done     (Done),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .DivByZero(DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        string        name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Wait (sampling on falling edges) until Done; returns edges counted after
    // the Start edge, and whether Busy stayed high throughout.
    task automatic wait_done(input logic expect_busy, output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (Done !== 1'b1 && lat < MAX_LAT) begin
            if (Busy !== expect_busy) busy_ok = 1'b0;
            @(negedge Clk);
            lat++;
        end
    endtask

    task automatic check_result(input string name, input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic dbz);
        check({name, " done"},  {31'd0, Done},      32'd1);
        check({name, " busy"},  {31'd0, Busy},      32'd0);
        check({name, " q"},     {24'd0, Quotient},  {24'd0, q});
        check({name, " r"},     {24'd0, Remainder}, {24'd0, r});
        check({name, " dbz"},   {31'd0, DivByZero}, {31'd0, dbz});
    endtask

    task automatic run_vec(input vec_t v);
        int   lat;
        logic busy_ok;
        @(negedge Clk);
        Dividend = v.dd;
        Divisor  = v.dv;
        Start    = 1'b1;
        @(negedge Clk);
        Start    = 1'b0;
        Dividend = W'($urandom);
        Divisor  = W'($urandom);
        wait_done(v.dv != 0, lat, busy_ok);
        check({v.name, " latency"}, lat, v.lat);
        check({v.name, " busy during op"}, {31'd0, busy_ok}, 32'd1);
        check_result(v.name, v.q, v.r, v.dbz);
        @(negedge Clk);
        check({v.name, " done single pulse"}, {31'd0, Done}, 32'd0);
        repeat (2) @(negedge Clk);
        check({v.name, " q held"}, {24'd0, Quotient},  {24'd0, v.q});
        check({v.name, " r held"}, {24'd0, Remainder}, {24'd0, v.r});
    endtask

    vec_t vecs[8];

    initial begin
        int   lat;
        logic busy_ok;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 8, "100/7"};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8, "255/1"};
        vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8, "5/9"};
        vecs[3] = '{8'd9,   8'd9,   8'd1,   8'd0,   1'b0, 8, "9/9"};
        vecs[4] = '{8'd200, 8'd255, 8'd0,   8'd200, 1'b0, 8, "200/255"};
        vecs[5] = '{8'd37,  8'd0,   8'd255, 8'd37,  1'b1, 0, "37/0"};
        vecs[6] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 8, "0/3"};
        vecs[7] = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 8, "255/16"};

        Rst      = 1'b0;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        #12;
        check("reset busy", {31'd0, Busy},      32'd0);
        check("reset done", {31'd0, Done},      32'd0);
        check("reset q",    {24'd0, Quotient},  32'd0);
        check("reset r",    {24'd0, Remainder}, 32'd0);
        check("reset dbz",  {31'd0, DivByZero}, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Second Start during CALC must be ignored.
        @(negedge Clk);
        Dividend = 8'd100; Divisor = 8'd7; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        Dividend = 8'd50; Divisor = 8'd5; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(1'b1, lat, busy_ok);
        check("ignored start latency", lat, 5);
        check_result("ignored start", 8'd14, 8'd2, 1'b0);
        @(negedge Clk);
        check("ignored start no restart", {31'd0, Busy}, 32'd0);

        // Start held high: the FIN cycle accepts the next operation.
        @(negedge Clk);
        Dividend = 8'd100; Divisor = 8'd7; Start = 1'b1;
        @(negedge Clk);
        Dividend = 8'd60; Divisor = 8'd8;
        wait_done(1'b1, lat, busy_ok);
        check("b2b first latency", lat, 8);
        check_result("b2b first", 8'd14, 8'd2, 1'b0);
        @(negedge Clk);
        Start = 1'b0;
        check("b2b accepted in fin", {31'd0, Busy}, 32'd1);
        wait_done(1'b1, lat, busy_ok);
        check("b2b second latency", lat, 8);
        check_result("b2b second", 8'd7, 8'd4, 1'b0);

        // Reset between edges mid-CALC aborts with no Done.
        @(negedge Clk);
        Dividend = 8'd100; Divisor = 8'd7; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        check("midop reset busy", {31'd0, Busy},      32'd0);
        check("midop reset q",    {24'd0, Quotient},  32'd0);
        check("midop reset r",    {24'd0, Remainder}, 32'd0);
        check("midop reset dbz",  {31'd0, DivByZero}, 32'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        busy_ok = 1'b1;
        repeat (10) begin
            @(negedge Clk);
            if (Done !== 1'b0 || Busy !== 1'b0) busy_ok = 1'b0;
        end
        check("midop reset no done", {31'd0, busy_ok}, 32'd1);
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
